// File: rtl/inst_mem_hs_if.sv
// Fetch-side bus of the instruction memory: request/valid fetch channel,
// flush strobe and the run-time loader write port.
//
// Handshake: a fetch is accepted on a rising edge where im_req = 1 and
// im_ready = 1 (or where im_flush = 1 restarts the block). im_valid is a
// one-cycle pulse; im_inst/im_fault are meaningful only while it is high,
// and im_inst keeps its value until the next im_valid or flush.
interface inst_mem_hs_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic        im_valid;
   logic [31:0] im_inst;
   logic        im_flush;
   logic        im_fault;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;

   // Fetch stage / loader agent side.
   modport master (
      output im_req, im_addr, im_flush, ld_we, ld_addr, ld_wdata,
      input  im_ready, im_valid, im_inst, im_fault
   );

   // Memory side.
   modport slave (
      input  im_req, im_addr, im_flush, ld_we, ld_addr, ld_wdata,
      output im_ready, im_valid, im_inst, im_fault
   );
endinterface

// File: rtl/inst_mem_hs.sv
// Synchronous-read instruction memory with request/valid handshake,
// LATENCY wait states, fetch flush and a loader write port.
// Optional feature macro: IMEM_FAULT_EN (misaligned / out-of-range fetches
// complete with im_fault = 1 and a NOP; such loader writes are dropped).
// o_dbg_state exposes the FSM state (1 = BUSY).
module inst_mem_hs #(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] RESET_NOP = 32'h00000013,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_mem_hs_if.slave  bus,
  output logic          o_dbg_state
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [1:0]  CNT_LOAD = 2'(LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic [31:0]   r_mem [DEPTH];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_cnt;
  logic [1:0]    w_cnt_nxt;
  logic          r_started;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          r_fault;
  logic          w_fault_nxt;
  logic [31:0]   r_inst;
  logic [31:0]   w_inst_nxt;
  logic [31:0]   r_hold;
  logic          r_hold_fault;

  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_ld_idx;
  logic [31:0]   w_rd_word;
  logic          w_rd_fault;
  logic          w_ld_ok;
  logic          w_accept;

  assign w_rd_idx  = bus.im_addr[AW+1:2];
  assign w_ld_idx  = bus.ld_addr[AW+1:2];
  // Read sampled at the accepting edge, before that edge's loader write lands.
  assign w_rd_word = r_mem[w_rd_idx];

`ifdef IMEM_FAULT_EN
  localparam logic [31:0] BYTE_SPAN = 32'(DEPTH * 4);

  assign w_rd_fault = (bus.im_addr[1:0] != 2'b00) || (bus.im_addr >= BYTE_SPAN);
  assign w_ld_ok    = bus.ld_we && (bus.ld_addr[1:0] == 2'b00) && (bus.ld_addr < BYTE_SPAN);
`else
  // Addresses wrap and byte offsets are ignored, so these bits are dead.
  logic w_unused_addr;

  assign w_rd_fault    = 1'b0;
  assign w_ld_ok       = bus.ld_we;
  assign w_unused_addr = ^{bus.im_addr[31:AW+2], bus.im_addr[1:0],
                           bus.ld_addr[31:AW+2], bus.ld_addr[1:0]};
`endif

  // A flush restarts the block, so it may take a new request even from BUSY.
  assign w_accept = r_started && bus.im_req && ((r_state == IDLE) || bus.im_flush);

  assign bus.im_ready = r_started && (r_state == IDLE);
  assign bus.im_valid = r_valid;
  assign bus.im_inst  = r_inst;
  assign bus.im_fault = r_fault;
  assign o_dbg_state  = (r_state == BUSY);

  // Next-state and output decode: flush first, then countdown, then accept.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    w_fault_nxt = 1'b0;
    w_inst_nxt  = r_inst;

    if (bus.im_flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 2'd0;
      w_inst_nxt  = RESET_NOP;
    end else if (r_state == BUSY) begin
      if (r_cnt == 2'd1) begin
        w_valid_nxt = 1'b1;
        w_fault_nxt = r_hold_fault;
        w_inst_nxt  = r_hold_fault ? RESET_NOP : r_hold;
        w_state_nxt = IDLE;
        w_cnt_nxt   = 2'd0;
      end else begin
        w_cnt_nxt = r_cnt - 2'd1;
      end
    end

    if (w_accept) begin
      if (LATENCY == 1) begin
        w_valid_nxt = 1'b1;
        w_fault_nxt = w_rd_fault;
        w_inst_nxt  = w_rd_fault ? RESET_NOP : w_rd_word;
        w_state_nxt = IDLE;
        w_cnt_nxt   = 2'd0;
      end else begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_LOAD;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_started <= 1'b0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_inst    <= RESET_NOP;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_started <= 1'b1;
      r_valid   <= w_valid_nxt;
      r_fault   <= w_fault_nxt;
      r_inst    <= w_inst_nxt;
    end
  end

  // Holding register: captures the fetched word so later loader writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_hold       <= w_rd_word;
      r_hold_fault <= w_rd_fault;
    end
  end

  // Loader write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_ld_ok) begin
      r_mem[w_ld_idx] <= bus.ld_wdata;
    end
  end

endmodule

// File: tb/tb_inst_mem_hs.sv
// Bench for inst_mem_hs: one instance with LATENCY=1 and one with LATENCY=3,
// sharing clock, reset and loader traffic. Build with +define+IMEM_FAULT_EN
// to exercise the fault path instead of address wrap.
module tb_inst_mem_hs;

   localparam logic [31:0] NOP = 32'h00000013;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   inst_mem_hs_if if1 ();
   inst_mem_hs_if if3 ();
   logic dbg1;
   logic dbg3;

   inst_mem_hs #(.DEPTH(512), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave), .o_dbg_state(dbg1)
   );
   inst_mem_hs #(.DEPTH(512), .LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(if3.slave), .o_dbg_state(dbg3)
   );

   // ---------------- scoreboard ----------------
   int          n_cmp  = 0;
   int          n_err  = 0;
   int          v1_cnt = 0;
   int          v3_cnt = 0;
   int          v_base;
   logic [32:0] exp1_q[$];
   logic [32:0] exp3_q[$];
   logic [31:0] model [512];

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected {fault, inst} for a fetch issued now.
   function automatic logic [32:0] exp_fetch(input logic [31:0] a);
`ifdef IMEM_FAULT_EN
      if ((a[1:0] != 2'b00) || (a >= 32'd2048)) return {1'b1, NOP};
`endif
      return {1'b0, model[a[10:2]]};
   endfunction

   // Output monitors: every valid pulse pops one expected entry.
   always @(negedge clk) begin
      if (if1.im_valid === 1'b1) begin
         v1_cnt++;
         check("d1_q_has_entry", {32'b0, exp1_q.size() != 0}, 33'd1);
         if (exp1_q.size() != 0) check("d1_data", {if1.im_fault, if1.im_inst}, exp1_q.pop_front());
      end else if (rst_n === 1'b1) begin
         check("d1_fault_idle", {32'b0, if1.im_fault}, 33'd0);
      end
   end

   always @(negedge clk) begin
      if (if3.im_valid === 1'b1) begin
         v3_cnt++;
         check("d3_q_has_entry", {32'b0, exp3_q.size() != 0}, 33'd1);
         if (exp3_q.size() != 0) check("d3_data", {if3.im_fault, if3.im_inst}, exp3_q.pop_front());
      end else if (rst_n === 1'b1) begin
         check("d3_fault_idle", {32'b0, if3.im_fault}, 33'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if1.im_req = 1'b0; if1.im_addr = '0; if1.im_flush = 1'b0;
      if1.ld_we  = 1'b0; if1.ld_addr = '0; if1.ld_wdata = '0;
      if3.im_req = 1'b0; if3.im_addr = '0; if3.im_flush = 1'b0;
      if3.ld_we  = 1'b0; if3.ld_addr = '0; if3.ld_wdata = '0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      if1.ld_we = 1'b1; if1.ld_addr = a; if1.ld_wdata = d;
      if3.ld_we = 1'b1; if3.ld_addr = a; if3.ld_wdata = d;
      step();
      if1.ld_we = 1'b0;
      if3.ld_we = 1'b0;
`ifdef IMEM_FAULT_EN
      if ((a[1:0] == 2'b00) && (a < 32'd2048)) model[a[10:2]] = d;
`else
      model[a[10:2]] = d;
`endif
   endtask

   task automatic fetch1(input logic [31:0] a);
      if1.im_req  = 1'b1;
      if1.im_addr = a;
      exp1_q.push_back(exp_fetch(a));
      step();
      if1.im_req = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] a;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) step();
      if1.im_req = 1'b1;   // requests during reset must be ignored
      if3.im_req = 1'b1;
      step();
      check("rst_ready1", {32'b0, if1.im_ready}, 33'd0);
      check("rst_ready3", {32'b0, if3.im_ready}, 33'd0);
      check("rst_valid1", {32'b0, if1.im_valid}, 33'd0);
      check("rst_inst1",  {1'b0, if1.im_inst}, {1'b0, NOP});
      check("rst_inst3",  {1'b0, if3.im_inst}, {1'b0, NOP});
      check("rst_fault3", {32'b0, if3.im_fault}, 33'd0);
      check("rst_dbg3",   {32'b0, dbg3}, 33'd0);
      rst_n = 1'b1;
      if1.im_req = 1'b0;
      if3.im_req = 1'b0;
      check("rel_ready1_before_edge", {32'b0, if1.im_ready}, 33'd0);
      step();
      check("rel_ready1", {32'b0, if1.im_ready}, 33'd1);
      check("rel_ready3", {32'b0, if3.im_ready}, 33'd1);
      check("rel_no_valid", {32'b0, if1.im_valid}, 33'd0);

      for (int i = 0; i < 16; i++) load(32'(i * 4), $urandom());
      load(32'h0C, 32'h004f1f13);
      load(32'h14, 32'h00510113);

      // Fetch with LATENCY=1
      fetch1(32'h0C);
      check("t1_valid", {32'b0, if1.im_valid}, 33'd1);
      check("t1_inst",  {1'b0, if1.im_inst}, {1'b0, 32'h004f1f13});
      check("t1_ready", {32'b0, if1.im_ready}, 33'd1);
      step();
      check("t1_pulse_end", {32'b0, if1.im_valid}, 33'd0);
      check("t1_inst_hold", {1'b0, if1.im_inst}, {1'b0, 32'h004f1f13});

      // LATENCY=3 back-to-back
      for (int k = 0; k < 2; k++) begin
         if3.im_req  = 1'b1;
         if3.im_addr = 32'(k * 4);
         exp3_q.push_back(exp_fetch(32'(k * 4)));
         step();
         if3.im_req = 1'b0;
         check("t2_busy_ready_a", {32'b0, if3.im_ready}, 33'd0);
         check("t2_busy_dbg",     {32'b0, dbg3}, 33'd1);
         step();
         check("t2_busy_ready_b", {32'b0, if3.im_ready}, 33'd0);
         check("t2_busy_valid",   {32'b0, if3.im_valid}, 33'd0);
         step();
         check("t2_valid", {32'b0, if3.im_valid}, 33'd1);
         check("t2_inst",  {1'b0, if3.im_inst}, {1'b0, model[k]});
         check("t2_ready_in_valid", {32'b0, if3.im_ready}, 33'd1);
      end

      // Flush mid-fetch with a simultaneous new request
      step();
      if3.im_req  = 1'b1;
      if3.im_addr = 32'h08;
      exp3_q.push_back(exp_fetch(32'h08));
      step();
      if3.im_addr  = 32'h10;
      if3.im_flush = 1'b1;
      exp3_q.delete();
      exp3_q.push_back(exp_fetch(32'h10));
      v_base = v3_cnt;
      step();
      if3.im_req   = 1'b0;
      if3.im_flush = 1'b0;
      check("t3_flush_valid", {32'b0, if3.im_valid}, 33'd0);
      check("t3_flush_inst",  {1'b0, if3.im_inst}, {1'b0, NOP});
      check("t3_flush_busy",  {32'b0, if3.im_ready}, 33'd0);
      step();
      check("t3_no_stale_valid", {32'b0, if3.im_valid}, 33'd0);
      step();
      check("t3_valid", {32'b0, if3.im_valid}, 33'd1);
      check("t3_inst",  {1'b0, if3.im_inst}, {1'b0, model[4]});
      // Flush during the valid cycle: pulse stands, next cycle shows NOP
      if3.im_flush = 1'b1;
      step();
      if3.im_flush = 1'b0;
      check("t3_vflush_valid", {32'b0, if3.im_valid}, 33'd0);
      check("t3_vflush_inst",  {1'b0, if3.im_inst}, {1'b0, NOP});
      check("t3_valid_count",  33'(v3_cnt - v_base), 33'd1);

      // Loader collision: read-before-write
      if1.im_req = 1'b1; if1.im_addr = 32'h14;
      if1.ld_we = 1'b1; if1.ld_addr = 32'h14; if1.ld_wdata = 32'hdeadbeef;
      if3.ld_we = 1'b1; if3.ld_addr = 32'h14; if3.ld_wdata = 32'hdeadbeef;
      exp1_q.push_back(exp_fetch(32'h14));
      step();
      if1.im_req = 1'b0; if1.ld_we = 1'b0; if3.ld_we = 1'b0;
      model[5] = 32'hdeadbeef;
      check("t4_old", {1'b0, if1.im_inst}, {1'b0, 32'h00510113});
      fetch1(32'h14);
      check("t4_new", {1'b0, if1.im_inst}, {1'b0, 32'hdeadbeef});

`ifdef IMEM_FAULT_EN
      fetch1(32'h802);
      check("t6_mis_valid", {32'b0, if1.im_valid}, 33'd1);
      check("t6_mis_fault", {if1.im_fault, if1.im_inst}, {1'b1, NOP});
      fetch1(32'h800);
      check("t6_oor_valid", {32'b0, if1.im_valid}, 33'd1);
      check("t6_oor_fault", {if1.im_fault, if1.im_inst}, {1'b1, NOP});
      load(32'h804, 32'h12345678);
      load(32'h06,  32'h87654321);
      fetch1(32'h04);
      check("t6_dropped_ld", {if1.im_fault, if1.im_inst}, {1'b0, model[1]});
`else
      fetch1(32'h800);
      check("t5_wrap", {if1.im_fault, if1.im_inst}, {1'b0, model[0]});
      fetch1(32'h807);
      check("t5_lowbits", {if1.im_fault, if1.im_inst}, {1'b0, model[1]});
`endif

      // Random back-to-back fetches: one per cycle at LATENCY=1
      for (int i = 0; i < 8; i++) begin
         a = 32'($urandom_range(0, 15) * 4);
         fetch1(a);
         check("rnd_valid", {32'b0, if1.im_valid}, 33'd1);
      end
      step();

      // Reset asserted mid-BUSY
      if3.im_req = 1'b1; if3.im_addr = 32'h0C;
      exp3_q.push_back(exp_fetch(32'h0C));
      step();
      if3.im_req = 1'b0;
      check("t7_busy", {32'b0, if3.im_ready}, 33'd0);
      rst_n = 1'b0;
      exp3_q.delete();
      v_base = v3_cnt;
      step();
      check("t7_rst_valid", {32'b0, if3.im_valid}, 33'd0);
      check("t7_rst_ready", {32'b0, if3.im_ready}, 33'd0);
      check("t7_rst_inst",  {1'b0, if3.im_inst}, {1'b0, NOP});
      step();
      rst_n = 1'b1;
      check("t7_ready_pre", {32'b0, if3.im_ready}, 33'd0);
      step();
      check("t7_ready_post", {32'b0, if3.im_ready}, 33'd1);
      step();
      check("t7_no_valid", 33'(v3_cnt - v_base), 33'd0);

      step();
      step();
      check("end_q1_empty", 33'(exp1_q.size()), 33'd0);
      check("end_q3_empty", 33'(exp3_q.size()), 33'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
